// File: rtl/snake_move_scheduler_if.sv
// Key-input and status bundle of snake_move_scheduler.
// The slave side is the scheduler; the master side is the game logic driving keys.
interface snake_move_scheduler_if;
  logic       key_valid_i;
  logic [7:0] key_code_i;
  logic       move_tick_o;
  logic [1:0] dir_o;
  logic [1:0] queue_level_o;
  logic [1:0] sched_state_o;

  modport slave (
    input  key_valid_i, key_code_i,
    output move_tick_o, dir_o, queue_level_o, sched_state_o
  );

  modport master (
    output key_valid_i, key_code_i,
    input  move_tick_o, dir_o, queue_level_o, sched_state_o
  );
endinterface

// File: rtl/snake_move_scheduler.sv
// Snake move scheduler: move-tick timer with speed-up, heading register and pending-direction storage.
// Define SNAKE_DIR_QUEUE_EN for a 2-entry direction FIFO; otherwise a single overwritable pending slot.
module snake_move_scheduler #(
  parameter int TICK_BASE = 2500000,
  parameter int TICK_MIN  = 625000,
  parameter int TICK_STEP = 125000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_snake_i,
  input  logic                   run_i,
  input  logic                   died_i,
  input  logic                   speed_up_i,
  snake_move_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10} state_e;

  localparam logic [23:0] BASE  = 24'(TICK_BASE);
  localparam logic [23:0] MIN   = 24'(TICK_MIN);
  localparam logic [23:0] STEP  = 24'(TICK_STEP);
  localparam logic [24:0] FLOOR = 25'(TICK_MIN) + 25'(TICK_STEP);

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] period_q, period_d;
  logic [1:0]  dir_q, dir_d;
  logic [1:0]  level_q, level_d;
  logic [1:0]  q0_q, q0_d;
  logic        tick_q, tick_d;
`ifdef SNAKE_DIR_QUEUE_EN
  logic [1:0]  q1_q, q1_d;
`endif

  logic        keyHit, due, pushOk;
  logic [1:0]  keyDir, levelPost, refDir;

  always_comb begin
    keyHit = bus.key_valid_i;
    keyDir = 2'b00;
    case (bus.key_code_i)
      8'h75:   keyDir = 2'b00;
      8'h72:   keyDir = 2'b01;
      8'h6B:   keyDir = 2'b10;
      8'h74:   keyDir = 2'b11;
      default: keyHit = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    dir_d     = dir_q;
    level_d   = level_q;
    q0_d      = q0_q;
`ifdef SNAKE_DIR_QUEUE_EN
    q1_d      = q1_q;
`endif
    tick_d    = 1'b0;
    levelPost = level_q;
    refDir    = dir_q;
    pushOk    = 1'b0;
    due       = (cnt_q >= period_q - 24'd1);

    if (init_snake_i) begin
      state_d  = RUN;
      dir_d    = 2'b11;
      period_d = BASE;
      cnt_d    = '0;
      level_d  = '0;
    end else if (died_i && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      level_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        HOLD: if (run_i) state_d = RUN;
        RUN: begin
          // A pause on the terminal count parks the counter so the tick fires right after resuming.
          if (!run_i) begin
            state_d = HOLD;
            if (!due) cnt_d = cnt_q + 24'd1;
          end else if (due) begin
            cnt_d  = '0;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end

          if (speed_up_i)
            period_d = ({1'b0, period_q} >= FLOOR) ? period_q - STEP : MIN;

          if (tick_d && level_q != 2'd0) begin
            dir_d     = q0_q;
            levelPost = level_q - 2'd1;
`ifdef SNAKE_DIR_QUEUE_EN
            q0_d      = q1_q;
`endif
          end

          // Keys are validated against the state left after this cycle's pop.
`ifdef SNAKE_DIR_QUEUE_EN
          refDir = (levelPost == 2'd2) ? q1_d : (levelPost == 2'd1) ? q0_d : dir_d;
          pushOk = keyHit && (levelPost != 2'd2) &&
                   (keyDir != refDir) && (keyDir != (refDir ^ 2'b01));
          if (pushOk) begin
            if (levelPost == 2'd0) q0_d = keyDir;
            else                   q1_d = keyDir;
          end
          level_d = levelPost + {1'b0, pushOk};
`else
          refDir = dir_d;
          pushOk = keyHit && (keyDir != refDir) && (keyDir != (refDir ^ 2'b01));
          if (pushOk) q0_d = keyDir;
          level_d = pushOk ? 2'd1 : levelPost;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= BASE;
      dir_q    <= 2'b11;
      level_q  <= '0;
      q0_q     <= '0;
`ifdef SNAKE_DIR_QUEUE_EN
      q1_q     <= '0;
`endif
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      level_q  <= level_d;
      q0_q     <= q0_d;
`ifdef SNAKE_DIR_QUEUE_EN
      q1_q     <= q1_d;
`endif
      tick_q   <= tick_d;
    end
  end

  assign bus.move_tick_o   = tick_q;
  assign bus.dir_o         = dir_q;
  assign bus.queue_level_o = level_q;
  assign bus.sched_state_o = state_q;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Testbench for snake_move_scheduler: vector table, directed corner sequences and a
// randomized run against a queue-based reference model of the scheduling rules.
module tb_snake_move_scheduler;

  localparam int A_BASE = 4;
  localparam int A_MIN  = 2;
  localparam int A_STEP = 1;
`ifdef SNAKE_DIR_QUEUE_EN
  localparam int QEND_DIR = 2;
  localparam int RST_KEY  = 'h72;
`else
  localparam int QEND_DIR = 1;
  localparam int RST_KEY  = 'h6B;
`endif

  typedef struct {
    logic       init;
    logic       run;
    logic       died;
    logic       speed;
    logic       kv;
    logic [7:0] kc;
    logic       eTick;
    logic [1:0] eDir;
    logic [1:0] eLvl;
    logic [1:0] eState;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic initSnake, run, died, speedUp;
  int   compared = 0;
  int   mismatched = 0;
  int   gap;
  int   rI, rR, rD, rS, rKv, rKc;
  vec_t vecs[14];

  int   mState, mDir, mPer, mCnt, mTick;
  int   mq[$];

  snake_move_scheduler_if ifA ();
  snake_move_scheduler_if ifB ();

  snake_move_scheduler #(.TICK_BASE(A_BASE), .TICK_MIN(A_MIN), .TICK_STEP(A_STEP)) dutA (
    .clk(clk), .rst_n(rst_n), .init_snake_i(initSnake), .run_i(run),
    .died_i(died), .speed_up_i(speedUp), .bus(ifA)
  );

  snake_move_scheduler #(.TICK_BASE(8), .TICK_MIN(4), .TICK_STEP(3)) dutB (
    .clk(clk), .rst_n(rst_n), .init_snake_i(initSnake), .run_i(run),
    .died_i(died), .speed_up_i(speedUp), .bus(ifB)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(int i, int r, int d, int s, int kv, int kc,
                                 int eT, int eD, int eL, int eS);
    vec_t v;
    v.init = i[0]; v.run = r[0]; v.died = d[0]; v.speed = s[0]; v.kv = kv[0];
    v.kc = kc[7:0]; v.eTick = eT[0]; v.eDir = eD[1:0]; v.eLvl = eL[1:0]; v.eState = eS[1:0];
    return v;
  endfunction

  // Drive one cycle of inputs, let the DUT take the next rising edge, then settle.
  task automatic applyStimulus(input int i, input int r, input int d, input int s,
                               input int kv, input int kc);
    initSnake = i[0];
    run       = r[0];
    died      = d[0];
    speedUp   = s[0];
    ifA.key_valid_i = kv[0];
    ifA.key_code_i  = kc[7:0];
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int eTick, input int eDir,
                          input int eLvl, input int eState);
    checkOutput({tag, ".move_tick"},   int'(ifA.move_tick_o),   eTick);
    checkOutput({tag, ".dir"},         int'(ifA.dir_o),         eDir);
    checkOutput({tag, ".queue_level"}, int'(ifA.queue_level_o), eLvl);
    checkOutput({tag, ".sched_state"}, int'(ifA.sched_state_o), eState);
  endtask

  task automatic measureGap(input int pulse, output int g);
    g = -1;
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(0, 1, 0, (k == 1 && pulse != 0) ? 1 : 0, 0, 0);
      if (ifB.move_tick_o) begin
        g = k;
        break;
      end
    end
  endtask

  task automatic modelReset();
    mState = 0; mDir = 3; mPer = A_BASE; mCnt = 0; mTick = 0;
    mq.delete();
  endtask

  // Reference behaviour: state 0 idle / 1 running / 2 paused, pending headings kept in a queue.
  task automatic modelStep(input int i, input int r, input int d, input int s,
                           input int kv, input int kc);
    int  k;
    int  refD;
    bit  kok;
    kok = 1'b1;
    case (kc)
      'h75:    k = 0;
      'h72:    k = 1;
      'h6B:    k = 2;
      'h74:    k = 3;
      default: begin k = 0; kok = 1'b0; end
    endcase
    mTick = 0;
    if (i != 0) begin
      mState = 1; mDir = 3; mPer = A_BASE; mCnt = 0;
      mq.delete();
    end else if (d != 0 && mState != 0) begin
      mState = 0; mCnt = 0;
      mq.delete();
    end else if (mState == 2) begin
      if (r != 0) mState = 1;
    end else if (mState == 1) begin
      if (r == 0) begin
        mState = 2;
        if (mCnt < mPer - 1) mCnt++;
      end else if (mCnt >= mPer - 1) begin
        mCnt = 0;
        mTick = 1;
      end else begin
        mCnt++;
      end
      if (s != 0) mPer = (mPer - A_STEP > A_MIN) ? mPer - A_STEP : A_MIN;
      if (mTick != 0 && mq.size() > 0) mDir = mq.pop_front();
      if (kv != 0 && kok) begin
`ifdef SNAKE_DIR_QUEUE_EN
        refD = (mq.size() > 0) ? mq[$] : mDir;
`else
        refD = mDir;
`endif
        if (k != refD && k != (refD ^ 1)) begin
`ifdef SNAKE_DIR_QUEUE_EN
          if (mq.size() < 2) mq.push_back(k);
`else
          mq.delete();
          mq.push_back(k);
`endif
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    initSnake = 1'b0; run = 1'b0; died = 1'b0; speedUp = 1'b0;
    ifA.key_valid_i = 1'b0; ifA.key_code_i = 8'h00;
    ifB.key_valid_i = 1'b0; ifB.key_code_i = 8'h00;

    vecs[0]  = mkVec(1, 1, 0, 0, 0, 'h00, 0, 3, 0, 1);
    vecs[1]  = mkVec(0, 1, 0, 0, 0, 'h00, 0, 3, 0, 1);
    vecs[2]  = mkVec(0, 1, 0, 0, 0, 'h00, 0, 3, 0, 1);
    vecs[3]  = mkVec(0, 1, 0, 0, 0, 'h00, 0, 3, 0, 1);
    vecs[4]  = mkVec(0, 1, 0, 0, 0, 'h00, 1, 3, 0, 1);
    vecs[5]  = mkVec(0, 1, 0, 0, 1, 'h6B, 0, 3, 0, 1);
    vecs[6]  = mkVec(0, 1, 0, 0, 1, 'h75, 0, 3, 1, 1);
    vecs[7]  = mkVec(0, 1, 0, 0, 0, 'h00, 0, 3, 1, 1);
    vecs[8]  = mkVec(0, 1, 0, 0, 0, 'h00, 1, 0, 0, 1);
    vecs[9]  = mkVec(0, 1, 0, 0, 1, 'h75, 0, 0, 0, 1);
    vecs[10] = mkVec(0, 1, 0, 0, 1, 'h12, 0, 0, 0, 1);
    vecs[11] = mkVec(0, 1, 0, 0, 1, 'h74, 0, 0, 1, 1);
    vecs[12] = mkVec(0, 1, 0, 0, 0, 'h00, 1, 3, 0, 1);
    vecs[13] = mkVec(0, 1, 0, 0, 0, 'h6B, 0, 3, 0, 1);

    #12;
    checkAll("reset", 0, 3, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 14; n++) begin
      applyStimulus(vecs[n].init, vecs[n].run, vecs[n].died, vecs[n].speed,
                    vecs[n].kv, vecs[n].kc);
      checkAll($sformatf("vec%0d", n), vecs[n].eTick, vecs[n].eDir,
               vecs[n].eLvl, vecs[n].eState);
    end

    applyStimulus(0, 1, 0, 0, 0, 0);
    checkAll("prePause", 0, 3, 0, 1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 0, 0, (k == 5) ? 1 : 0, 'h75);
      checkAll($sformatf("hold%0d", k), 0, 3, 0, 2);
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkAll("resume", 0, 3, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkAll("resumeTick", 1, 3, 0, 1);

    applyStimulus(0, 1, 0, 0, 1, 'h75);
    checkAll("keyUp", 0, 3, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkAll("keyUpWait", 0, 3, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkAll("keyUpTick", 1, 0, 0, 1);

    applyStimulus(0, 1, 1, 0, 1, 'h74);
    checkAll("died", 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkAll($sformatf("idle%0d", k), 0, 0, 0, 0);
    end
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkAll("initOverDied", 0, 3, 0, 1);

`ifdef SNAKE_DIR_QUEUE_EN
    applyStimulus(0, 1, 0, 0, 1, 'h75);
    checkAll("fifoUp", 0, 3, 1, 1);
    applyStimulus(0, 1, 0, 0, 1, 'h6B);
    checkAll("fifoLeft", 0, 3, 2, 1);
    applyStimulus(0, 1, 0, 0, 1, 'h72);
    checkAll("fifoFullDrop", 0, 3, 2, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkAll("fifoTick1", 1, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkAll("fifoWait", 0, 0, 1, 1);
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkAll("fifoTick2", 1, 2, 0, 1);
`else
    applyStimulus(0, 1, 0, 0, 1, 'h75);
    checkAll("slotUp", 0, 3, 1, 1);
    applyStimulus(0, 1, 0, 0, 1, 'h72);
    checkAll("slotOverwrite", 0, 3, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkAll("slotWait", 0, 3, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkAll("slotTick", 1, 1, 0, 1);
`endif

    applyStimulus(0, 1, 0, 0, 1, RST_KEY);
    checkAll("preReset", 0, QEND_DIR, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkAll("preResetDue", 0, QEND_DIR, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("asyncReset", 0, 3, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkAll($sformatf("postReset%0d", k), 0, 3, 0, 0);
    end

    applyStimulus(1, 1, 0, 0, 0, 0);
    measureGap(0, gap);
    checkOutput("speedGapBase", gap, 8);
    measureGap(1, gap);
    checkOutput("speedGap1", gap, 5);
    measureGap(1, gap);
    checkOutput("speedGap2", gap, 4);
    measureGap(1, gap);
    checkOutput("speedGap3", gap, 4);

    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    modelReset();
    for (int n = 0; n < 600; n++) begin
      rI  = (n == 0 || $urandom_range(0, 59) == 0) ? 1 : 0;
      rR  = ($urandom_range(0, 9) != 0) ? 1 : 0;
      rD  = ($urandom_range(0, 39) == 0) ? 1 : 0;
      rS  = ($urandom_range(0, 11) == 0) ? 1 : 0;
      rKv = ($urandom_range(0, 2) == 0) ? 1 : 0;
      case ($urandom_range(0, 4))
        0:       rKc = 'h75;
        1:       rKc = 'h72;
        2:       rKc = 'h6B;
        3:       rKc = 'h74;
        default: rKc = int'($urandom_range(0, 255));
      endcase
      applyStimulus(rI, rR, rD, rS, rKv, rKc);
      modelStep(rI, rR, rD, rS, rKv, rKc);
      checkAll($sformatf("rand%0d", n), mTick, mDir, mq.size(), mState);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
